// File: rtl/bp_pkg.sv
// Shared definitions for the branch target predictor.
//   - bp_ctr_e     : 2-bit direction counter encodings (SNT/WNT/WT/ST)
//   - BP_MODE_*    : prediction mode selectors for the MODE parameter
//   - sat_ctr_next : saturating increment/decrement of a direction counter
package bp_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_e;

    localparam int BP_MODE_1BIT = 0;
    localparam int BP_MODE_2BIT = 1;

    // Move the counter one step towards ST (inc=1) or SNT (inc=0), holding at the ends.
    function automatic bp_ctr_e sat_ctr_next(input bp_ctr_e ctr, input logic inc);
        bp_ctr_e res;
        res = ctr;
        case (ctr)
            SNT:     res = inc ? WNT : SNT;
            WNT:     res = inc ? WT  : SNT;
            WT:      res = inc ? ST  : WNT;
            ST:      res = inc ? ST  : WT;
            default: res = WT;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/bp_stats.sv
// Saturating prediction statistics: total resolved branches, correct
// predictions and mispredictions. Counters hold at all-ones instead of wrapping.
//   clk, rst       : clock, synchronous active-high reset
//   i_upd          : a branch resolved this cycle (already qualified by stall)
//   i_mispredict   : that branch was mispredicted
//   i_clr          : synchronous clear, takes priority over i_upd
//   o_br_cnt/o_hit_cnt/o_miss_cnt : counter values (registered)
module bp_stats #(
    parameter int CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_upd,
    input  logic             i_mispredict,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_hit_cnt,
    output logic [CNT_W-1:0] o_miss_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt;

    // Counter state: reset, clear, then saturating count of resolved branches.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_br_cnt   <= '0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (i_upd) begin
            if (r_br_cnt != CNT_MAX) begin
                r_br_cnt <= r_br_cnt + CNT_ONE;
            end
            if (!i_mispredict) begin
                if (r_hit_cnt != CNT_MAX) begin
                    r_hit_cnt <= r_hit_cnt + CNT_ONE;
                end
            end else if (r_miss_cnt != CNT_MAX) begin
                r_miss_cnt <= r_miss_cnt + CNT_ONE;
            end
        end
    end

    assign o_br_cnt   = r_br_cnt;
    assign o_hit_cnt  = r_hit_cnt;
    assign o_miss_cnt = r_miss_cnt;

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped tagged branch target buffer with per-entry direction counter.
// Looked up combinationally by the fetch PC, updated by branches resolved in EX.
//   clk, rst                 : clock, synchronous active-high reset
//   pc_f                     : fetch PC
//   pred_taken_f/pred_target_f : combinational prediction for pc_f
//   upd_*_e, stall_e         : resolved-branch information from EX
//   mispredict_e             : combinational flush request
//   clr_stats                : clears the statistics only
//   br_cnt/hit_cnt/miss_cnt  : saturating statistics
module branch_target_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int MODE    = BP_MODE_2BIT,
    parameter int CNT_W   = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_f,
    output logic             pred_taken_f,
    output logic [31:0]      pred_target_f,
    input  logic             upd_valid_e,
    input  logic             stall_e,
    input  logic [31:0]      upd_pc_e,
    input  logic             upd_taken_e,
    input  logic [31:0]      upd_target_e,
    input  logic             upd_pred_e,
    input  logic [31:0]      upd_pred_target_e,
    output logic             mispredict_e,
    input  logic             clr_stats,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    // Only valid is reset; tag/target/ctr are gated by it, which keeps them RAM-mappable.
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    bp_ctr_e            r_ctr    [ENTRIES];

    logic [IDX_W-1:0] w_f_idx;
    logic [TAG_W-1:0] w_f_tag;
    logic             w_f_hit;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_uhit;
    logic             w_upd;
    logic             w_unused_pc_bits;

    assign w_f_idx = pc_f[IDX_W+1:2];
    assign w_f_tag = pc_f[31:IDX_W+2];
    assign w_f_hit = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);

    assign w_u_idx = upd_pc_e[IDX_W+1:2];
    assign w_u_tag = upd_pc_e[31:IDX_W+2];
    assign w_uhit  = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);

    assign w_upd   = upd_valid_e && !stall_e;

    // Instructions are word aligned; the byte offset never selects anything.
    assign w_unused_pc_bits = ^{pc_f[1:0], upd_pc_e[1:0]};

    // Fetch-side lookup: target on hit, direction from the counter MSB in 2-bit mode.
    always_comb begin
        pred_taken_f  = 1'b0;
        pred_target_f = 32'd0;
        if (w_f_hit) begin
            pred_target_f = r_target[w_f_idx];
            if (MODE == BP_MODE_2BIT) begin
                pred_taken_f = (r_ctr[w_f_idx] == WT) || (r_ctr[w_f_idx] == ST);
            end else begin
                pred_taken_f = 1'b1;
            end
        end else begin
            pred_taken_f  = 1'b0;
            pred_target_f = 32'd0;
        end
    end

    // Wrong direction, or right "taken" direction with the wrong target.
    assign mispredict_e = w_upd && ((upd_pred_e ^ upd_taken_e) ||
                          (upd_pred_e && upd_taken_e && (upd_pred_target_e != upd_target_e)));

    // Valid bits: cleared by reset, set on allocation, dropped on a not-taken hit in 1-bit mode.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_upd) begin
            if (w_uhit) begin
                if (!upd_taken_e && (MODE == BP_MODE_1BIT)) begin
                    r_valid[w_u_idx] <= 1'b0;
                end
            end else if (upd_taken_e) begin
                r_valid[w_u_idx] <= 1'b1;
            end
        end
    end

    // Tag/target storage: target refreshed on every taken update, tag only on allocation.
    always_ff @(posedge clk) begin
        if (!rst && w_upd && upd_taken_e) begin
            r_target[w_u_idx] <= upd_target_e;
            if (!w_uhit) begin
                r_tag[w_u_idx] <= w_u_tag;
            end
        end
    end

    // Direction counter: trained on hits, seeded weakly-taken on allocation.
    always_ff @(posedge clk) begin
        if (!rst && w_upd) begin
            if (w_uhit) begin
                r_ctr[w_u_idx] <= sat_ctr_next(r_ctr[w_u_idx], upd_taken_e);
            end else if (upd_taken_e) begin
                r_ctr[w_u_idx] <= WT;
            end
        end
    end

    bp_stats #(
        .CNT_W (CNT_W)
    ) u_stats (
        .clk          (clk),
        .rst          (rst),
        .i_upd        (w_upd),
        .i_mispredict (mispredict_e),
        .i_clr        (clr_stats),
        .o_br_cnt     (br_cnt),
        .o_hit_cnt    (hit_cnt),
        .o_miss_cnt   (miss_cnt)
    );

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor. A second instance with 4-bit
// statistics shares all stimulus and is used for the saturation check.
module tb_branch_target_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_f;
    logic        upd_valid_e;
    logic        stall_e;
    logic [31:0] upd_pc_e;
    logic        upd_taken_e;
    logic [31:0] upd_target_e;
    logic        upd_pred_e;
    logic [31:0] upd_pred_target_e;
    logic        clr_stats;

    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        mispredict_e;
    logic [19:0] br_cnt, hit_cnt, miss_cnt;

    logic        pred_taken_f4;
    logic [31:0] pred_target_f4;
    logic        mispredict_e4;
    logic [3:0]  br_cnt4, hit_cnt4, miss_cnt4;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    branch_target_predictor #(.ENTRIES(64), .MODE(1), .CNT_W(20)) dut (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_taken_f(pred_taken_f), .pred_target_f(pred_target_f),
        .upd_valid_e(upd_valid_e), .stall_e(stall_e), .upd_pc_e(upd_pc_e),
        .upd_taken_e(upd_taken_e), .upd_target_e(upd_target_e),
        .upd_pred_e(upd_pred_e), .upd_pred_target_e(upd_pred_target_e),
        .mispredict_e(mispredict_e), .clr_stats(clr_stats),
        .br_cnt(br_cnt), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    branch_target_predictor #(.ENTRIES(64), .MODE(1), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .pc_f(pc_f),
        .pred_taken_f(pred_taken_f4), .pred_target_f(pred_target_f4),
        .upd_valid_e(upd_valid_e), .stall_e(stall_e), .upd_pc_e(upd_pc_e),
        .upd_taken_e(upd_taken_e), .upd_target_e(upd_target_e),
        .upd_pred_e(upd_pred_e), .upd_pred_target_e(upd_pred_target_e),
        .mispredict_e(mispredict_e4), .clr_stats(clr_stats),
        .br_cnt(br_cnt4), .hit_cnt(hit_cnt4), .miss_cnt(miss_cnt4)
    );

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_upd(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                           input logic pr, input logic [31:0] ptgt);
        upd_valid_e       = 1'b1;
        upd_pc_e          = pc;
        upd_taken_e       = tk;
        upd_target_e      = tgt;
        upd_pred_e        = pr;
        upd_pred_target_e = ptgt;
        #1;
    endtask

    // One resolved branch: check flush request, commit it, release the port.
    task automatic do_upd(input string tag, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic pr, input logic [31:0] ptgt,
                          input logic exp_misp);
        set_upd(pc, tk, tgt, pr, ptgt);
        check_value(tag, {31'd0, mispredict_e}, {31'd0, exp_misp});
        tick();
        upd_valid_e = 1'b0;
        #1;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic exp_tk,
                        input logic [31:0] exp_tgt);
        pc_f = pc;
        #1;
        check_value({tag, "_taken"}, {31'd0, pred_taken_f}, {31'd0, exp_tk});
        check_value({tag, "_target"}, pred_target_f, exp_tgt);
    endtask

    task automatic check_cnts(input string tag, input int br, input int hit, input int miss);
        check_value({tag, "_br"},   {12'd0, br_cnt},   br);
        check_value({tag, "_hit"},  {12'd0, hit_cnt},  hit);
        check_value({tag, "_miss"}, {12'd0, miss_cnt}, miss);
    endtask

    initial begin
        rst = 1'b1; pc_f = 32'h100; upd_valid_e = 1'b0; stall_e = 1'b0;
        upd_pc_e = 32'd0; upd_taken_e = 1'b0; upd_target_e = 32'd0;
        upd_pred_e = 1'b0; upd_pred_target_e = 32'd0; clr_stats = 1'b0;
        tick();
        tick();
        look("in_reset", 32'h100, 1'b0, 32'h0);
        rst = 1'b0;
        tick();
        look("reset", 32'h100, 1'b0, 32'h0);
        check_cnts("reset", 0, 0, 0);

        // Allocation, then 2-bit training: WT -> WNT -> WT -> ST -> WT
        do_upd("alloc_misp", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
        check_cnts("alloc", 1, 0, 1);
        look("alloc", 32'h100, 1'b1, 32'h80);
        do_upd("nt1_misp", 32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        look("wnt", 32'h100, 1'b0, 32'h80);
        do_upd("t1_misp", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
        look("wt", 32'h100, 1'b1, 32'h80);
        check_cnts("train", 3, 0, 3);
        for (int i = 0; i < 3; i++) begin
            do_upd("t3_misp", 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 1'b0);
        end
        check_cnts("st", 6, 3, 3);
        do_upd("st_nt_misp", 32'h100, 1'b0, 32'h0, 1'b1, 32'h80, 1'b1);
        look("st_nt", 32'h100, 1'b1, 32'h80);

        // Right direction, wrong target
        do_upd("tgt_misp", 32'h100, 1'b1, 32'h90, 1'b1, 32'h80, 1'b1);
        look("tgt", 32'h100, 1'b1, 32'h90);
        check_cnts("tgt", 8, 3, 5);

        // Same-index read while writing sees the old target
        pc_f = 32'h100;
        set_upd(32'h100, 1'b1, 32'hA0, 1'b1, 32'h90);
        check_value("rw_old_target", pred_target_f, 32'h90);
        tick();
        upd_valid_e = 1'b0;
        look("rw_new", 32'h100, 1'b1, 32'hA0);

        // Aliasing: 0x200 shares index 0 with 0x100
        look("alias_miss", 32'h200, 1'b0, 32'h0);
        do_upd("alias_misp", 32'h200, 1'b1, 32'h300, 1'b0, 32'h0, 1'b1);
        look("alias_old", 32'h100, 1'b0, 32'h0);
        look("alias_new", 32'h200, 1'b1, 32'h300);
        check_cnts("alias", 10, 3, 7);

        // Stall holds the update off until it drops
        stall_e = 1'b1;
        set_upd(32'h400, 1'b1, 32'h40, 1'b0, 32'h0);
        check_value("stall_misp", {31'd0, mispredict_e}, 32'd0);
        tick(); tick(); tick();
        check_cnts("stall", 10, 3, 7);
        look("stall_tbl", 32'h400, 1'b0, 32'h0);
        stall_e = 1'b0;
        #1;
        check_value("unstall_misp", {31'd0, mispredict_e}, 32'd1);
        tick();
        upd_valid_e = 1'b0;
        check_cnts("unstall", 11, 3, 8);
        look("unstall_tbl", 32'h400, 1'b1, 32'h40);

        // Not-taken miss allocates nothing
        do_upd("ntmiss_misp", 32'h104, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
        look("ntmiss", 32'h104, 1'b0, 32'h0);
        check_cnts("ntmiss", 12, 4, 8);

        // Reset discards a pending update and invalidates the table
        rst = 1'b1;
        set_upd(32'h108, 1'b1, 32'h50, 1'b0, 32'h0);
        check_value("rst_misp_comb", {31'd0, mispredict_e}, 32'd1);
        tick();
        rst = 1'b0;
        upd_valid_e = 1'b0;
        #1;
        look("rst_pending", 32'h108, 1'b0, 32'h0);
        look("rst_inval", 32'h400, 1'b0, 32'h0);
        check_cnts("rst2", 0, 0, 0);

        // clr_stats beats a concurrent update and leaves the table alone
        do_upd("pre_clr_misp", 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1);
        check_cnts("pre_clr", 1, 0, 1);
        clr_stats = 1'b1;
        set_upd(32'h104, 1'b0, 32'h0, 1'b0, 32'h0);
        tick();
        clr_stats = 1'b0;
        upd_valid_e = 1'b0;
        #1;
        check_cnts("clr", 0, 0, 0);
        look("clr_tbl", 32'h100, 1'b1, 32'h80);

        // Saturation: 20 correct predictions
        set_upd(32'h10C, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        upd_valid_e = 1'b0;
        #1;
        check_cnts("sat20", 20, 20, 0);
        check_value("sat_br4",   {28'd0, br_cnt4},   32'd15);
        check_value("sat_hit4",  {28'd0, hit_cnt4},  32'd15);
        check_value("sat_miss4", {28'd0, miss_cnt4}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
